box_overlay_multi: RTL and testbench
====================================

# box_overlay_multi

Pixel-stream overlay that draws up to NUM_BOX independent rectangular bounding boxes, each with its own colour, thickness-limited border, optional label stripe and optional blink, on top of the live video in the ISP display path. It sits after the recognition/colour-segmentation stages and before the video output encoder. It generates its own pixel/line counters from i_de/i_vsync. Box coordinates are shadow-latched once per frame so boxes never tear mid-frame.

## Interface
- NUM_BOX, 4, number of boxes (1..8); box 0 has highest priority
- CW, 12, coordinate width in bits
- THICK, 2, border thickness in pixels (1..8)
- LABEL_OFS, 2, label stripe sits LABEL_OFS lines above the box top edge
- BLINK_FRAMES, 15, frames per blink half-period (≥1)
- VS_POL, 1, active level of i_vsync
- pixelclk  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- i_rgb  in  24  input pixel {R,G,B}
- i_hsync, i_vsync, i_de  in  1 each  input sync/data-enable
- box_en  in  NUM_BOX  per-box enable
- box_blink  in  NUM_BOX  per-box blink mode
- box_hl, box_hr, box_vl, box_vr  in  NUM_BOX*CW each  packed left/right/top/bottom coordinates, box k at bits [k*CW +: CW]
- box_color  in  NUM_BOX*24  border colour per box
- label_rgb  in  NUM_BOX*24  label stripe colour per box
- o_rgb  out  24  overlaid pixel
- o_hsync, o_vsync, o_de  out  1 each  syncs delayed to match o_rgb
- o_hit  out  NUM_BOX  per-box border/label hit for the pixel on o_rgb

## Operation
- Frame start (FS): i_vsync transitions to VS_POL level (edge detect on registered i_vsync).
- Counters: hcnt increments each cycle i_de=1, clears to 0 the cycle after i_de falls; vcnt clears on FS, increments once per i_de falling edge. Both saturate at 2^CW−1 (no wrap).
- Shadow latch: on FS cycle all box_* inputs are copied to shadow registers; the overlay uses shadows only. Changes between FS events have no visible effect.
- Blink: frame counter counts FS events 0..BLINK_FRAMES−1, wraps to 0 and toggles blink_phase. Box with shadow box_blink=1 is visible only when blink_phase=0; non-blink boxes always visible.
- Box k valid iff shadow en=1, visible, hl<hr and vl<vr; invalid boxes never hit.
- Border hit (coordinates inclusive, x=hcnt, y=vcnt): (vl≤y≤vr and (hl≤x≤hl+THICK−1 or hr−THICK+1≤x≤hr)) or (hl≤x≤hr and (vl≤y≤vl+THICK−1 or vr−THICK+1≤y≤vr)). Thickness clamps naturally when box is narrower than 2·THICK.
- Label hit: vl≥LABEL_OFS, y==vl−LABEL_OFS, hl<x<hr.
- Colour select when delayed de=1: lowest-index box with border hit → its box_color; else lowest-index box with label hit → its label_rgb; else i_rgb. Border of any box beats label of any box. When delayed de=0, o_rgb = delayed i_rgb, o_hit=0.
- Arithmetic: edge/label bounds computed at CW+1 bits to avoid underflow/overflow; no wrap-around matches.
- Reset (any time, incl. mid-frame): counters, shadows, frame counter, blink_phase, pipeline all 0; o_rgb=0, o_hsync=o_vsync=o_de=0, o_hit=0. No overlay until first FS after reset.

## Timing
- Latency 2 cycles, fixed: stage 1 registers per-box hit flags and delayed pixel/syncs; stage 2 registers priority mux output. o_hsync/o_vsync/o_de = inputs delayed exactly 2 cycles.
- Shadow values take effect for the first pixel after the FS cycle.
- Blink phase changes on the FS that wraps the frame counter; applies to that whole frame.
- Throughput one pixel per clock, no stalls.

## Test plan
- Single box 0: hl=10,hr=20,vl=5,vr=15, color 00FF00, THICK=2 → pixels x∈{10,11,19,20}, y 5..15 and y∈{5,6,14,15}, x 10..20 are 00FF00; (15,10) passes i_rgb; o_de exactly 2 cycles after i_de.
- Label: same box, label_rgb FF0000, LABEL_OFS=2 → row y=3, x 11..19 FF0000; x=10,20 on y=3 pass through; vl=1 → no label row.
- Overlap: box0 (10,20,5,15) blue, box1 (15,30,5,15) red → pixel (20,10) blue, (30,10) red, o_hit=2'b11 at (15,5).
- Shadow: change box_hl 10→40 mid-frame → current frame unchanged, next frame border at 40; hl=hr or vl>vr → no hit.
- Blink: BLINK_FRAMES=2, box_blink=1 → box visible frames 0–1, hidden 2–3, visible 4–5.
- Reset asserted mid-line → next cycle o_rgb=0, syncs 0; after release no overlay until next FS, then normal.

Source files
------------

// File: rtl/box_overlay_multi.sv
// Multi-box bounding-box overlay for the display path. Box geometry is shadowed
// once per frame; two-stage pipeline (hit flags, then priority colour mux).
module box_overlay_multi #(
   parameter int   NUM_BOX      = 4,
   parameter int   CW           = 12,
   parameter int   THICK        = 2,
   parameter int   LABEL_OFS    = 2,
   parameter int   BLINK_FRAMES = 15,
   parameter logic VS_POL       = 1'b1
) (
   input  logic                    pixelclk,
   input  logic                    reset_n,
   input  logic [23:0]             i_rgb,
   input  logic                    i_hsync,
   input  logic                    i_vsync,
   input  logic                    i_de,
   input  logic [NUM_BOX-1:0]      box_en,
   input  logic [NUM_BOX-1:0]      box_blink,
   input  logic [NUM_BOX*CW-1:0]   box_hl,
   input  logic [NUM_BOX*CW-1:0]   box_hr,
   input  logic [NUM_BOX*CW-1:0]   box_vl,
   input  logic [NUM_BOX*CW-1:0]   box_vr,
   input  logic [NUM_BOX*24-1:0]   box_color,
   input  logic [NUM_BOX*24-1:0]   label_rgb,
   output logic [23:0]             o_rgb,
   output logic                    o_hsync,
   output logic                    o_vsync,
   output logic                    o_de,
   output logic [NUM_BOX-1:0]      o_hit
);

   localparam int              FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0]   F_LAST = FW'(BLINK_FRAMES - 1);
   localparam logic [CW:0]     TM1    = (CW+1)'(THICK - 1);
   localparam logic [CW:0]     LOFS   = (CW+1)'(LABEL_OFS);
   localparam logic [CW-1:0]   CMAX   = '1;

   logic                           vs_q, de_q;
   logic [CW-1:0]                  hcnt_q, vcnt_q;
   logic [NUM_BOX-1:0]             sh_en_q, sh_blink_q;
   logic [NUM_BOX-1:0][CW-1:0]     sh_hl_q, sh_hr_q, sh_vl_q, sh_vr_q;
   logic [NUM_BOX-1:0][23:0]       sh_col_q, sh_lab_q;
   logic [FW-1:0]                  fcnt_q;
   logic                           phase_q, started_q;

   logic [23:0]                    s1_rgb_q;
   logic                           s1_hs_q, s1_vs_q, s1_de_q;
   logic [NUM_BOX-1:0]             s1_bhit_q, s1_lhit_q;

   logic                           fs, de_fall;
   logic [CW:0]                    xe, ye;
   logic [NUM_BOX-1:0]             bhit_d, lhit_d;
   logic [23:0]                    rgb_d;
   logic [NUM_BOX-1:0]             hit_d;

   assign fs      = (i_vsync == VS_POL) && (vs_q != VS_POL);
   assign de_fall = de_q && !i_de;
   assign xe      = {1'b0, hcnt_q};
   assign ye      = {1'b0, vcnt_q};

   // Bounds are compared one bit wider and subtractions are moved to the other
   // side of each compare, so no edge or label row can wrap around.
   for (genvar k = 0; k < NUM_BOX; k++) begin : g_box
      logic [CW:0] hl, hr, vl, vr;
      logic        valid, in_x, in_y, edge_x, edge_y;
      assign hl     = {1'b0, sh_hl_q[k]};
      assign hr     = {1'b0, sh_hr_q[k]};
      assign vl     = {1'b0, sh_vl_q[k]};
      assign vr     = {1'b0, sh_vr_q[k]};
      assign valid  = sh_en_q[k] && !(sh_blink_q[k] && phase_q) && (hl < hr) && (vl < vr);
      assign in_x   = (xe >= hl) && (xe <= hr);
      assign in_y   = (ye >= vl) && (ye <= vr);
      assign edge_x = ((xe >= hl) && (xe <= hl + TM1)) || ((xe + TM1 >= hr) && (xe <= hr));
      assign edge_y = ((ye >= vl) && (ye <= vl + TM1)) || ((ye + TM1 >= vr) && (ye <= vr));
      assign bhit_d[k] = valid && ((in_y && edge_x) || (in_x && edge_y));
      assign lhit_d[k] = valid && (ye + LOFS == vl) && (xe > hl) && (xe < hr);
   end

   // Labels first, then borders, each scanned high to low so the lowest index wins
   // and any border beats any label.
   always_comb begin
      rgb_d = s1_rgb_q;
      hit_d = '0;
      if (s1_de_q) begin
         hit_d = s1_bhit_q | s1_lhit_q;
         for (int k = NUM_BOX - 1; k >= 0; k--) begin
            if (s1_lhit_q[k]) rgb_d = sh_lab_q[k];
         end
         for (int k = NUM_BOX - 1; k >= 0; k--) begin
            if (s1_bhit_q[k]) rgb_d = sh_col_q[k];
         end
      end
   end

   always_ff @(posedge pixelclk) begin
      if (!reset_n) begin
         vs_q       <= 1'b0;
         de_q       <= 1'b0;
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         sh_en_q    <= '0;
         sh_blink_q <= '0;
         sh_hl_q    <= '0;
         sh_hr_q    <= '0;
         sh_vl_q    <= '0;
         sh_vr_q    <= '0;
         sh_col_q   <= '0;
         sh_lab_q   <= '0;
         fcnt_q     <= '0;
         phase_q    <= 1'b0;
         started_q  <= 1'b0;
         s1_rgb_q   <= '0;
         s1_hs_q    <= 1'b0;
         s1_vs_q    <= 1'b0;
         s1_de_q    <= 1'b0;
         s1_bhit_q  <= '0;
         s1_lhit_q  <= '0;
         o_rgb      <= '0;
         o_hsync    <= 1'b0;
         o_vsync    <= 1'b0;
         o_de       <= 1'b0;
         o_hit      <= '0;
      end else begin
         vs_q <= i_vsync;
         de_q <= i_de;

         if (i_de) begin
            if (hcnt_q != CMAX) hcnt_q <= hcnt_q + CW'(1);
         end else if (de_q) begin
            hcnt_q <= '0;
         end

         if (fs) vcnt_q <= '0;
         else if (de_fall && (vcnt_q != CMAX)) vcnt_q <= vcnt_q + CW'(1);

         // The first FS after reset opens blink frame 0 without advancing the count.
         if (fs) begin
            sh_en_q    <= box_en;
            sh_blink_q <= box_blink;
            sh_hl_q    <= box_hl;
            sh_hr_q    <= box_hr;
            sh_vl_q    <= box_vl;
            sh_vr_q    <= box_vr;
            sh_col_q   <= box_color;
            sh_lab_q   <= label_rgb;
            if (!started_q) begin
               started_q <= 1'b1;
            end else if (fcnt_q == F_LAST) begin
               fcnt_q  <= '0;
               phase_q <= ~phase_q;
            end else begin
               fcnt_q <= fcnt_q + FW'(1);
            end
         end

         s1_rgb_q  <= i_rgb;
         s1_hs_q   <= i_hsync;
         s1_vs_q   <= i_vsync;
         s1_de_q   <= i_de;
         s1_bhit_q <= bhit_d;
         s1_lhit_q <= lhit_d;

         o_rgb   <= rgb_d;
         o_hit   <= hit_d;
         o_hsync <= s1_hs_q;
         o_vsync <= s1_vs_q;
         o_de    <= s1_de_q;
      end
   end

endmodule

// File: tb/tb_box_overlay_multi.sv
// Directed bench for box_overlay_multi: streams small frames, captures the overlaid
// picture by pixel position and compares a table of hand-computed probe points.
module tb_box_overlay_multi;

   localparam int NB = 4, CW = 12, HACT = 48, VACT = 20, HBL = 6;
   localparam logic [23:0] GRN = 24'h00FF00, RED = 24'hFF0000, BLU = 24'h0000FF;
   localparam logic [23:0] CYA = 24'h00FFFF, YEL = 24'hFFFF00, MAG = 24'hFF00FF;
   localparam logic [23:0] BLANK_RGB = 24'h0C0C0C;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [23:0]         i_rgb;
   logic                i_hsync, i_vsync, i_de;
   logic [NB-1:0]       box_en, box_blink;
   logic [NB*CW-1:0]    box_hl, box_hr, box_vl, box_vr;
   logic [NB*24-1:0]    box_color, label_rgb;
   logic [23:0]         o_rgb;
   logic                o_hsync, o_vsync, o_de;
   logic [NB-1:0]       o_hit;

   always #5 clk = ~clk;

   box_overlay_multi #(
      .NUM_BOX(NB), .CW(CW), .THICK(2), .LABEL_OFS(2), .BLINK_FRAMES(2), .VS_POL(1'b1)
   ) dut (
      .pixelclk(clk), .reset_n(reset_n),
      .i_rgb(i_rgb), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
      .box_en(box_en), .box_blink(box_blink),
      .box_hl(box_hl), .box_hr(box_hr), .box_vl(box_vl), .box_vr(box_vr),
      .box_color(box_color), .label_rgb(label_rgb),
      .o_rgb(o_rgb), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de), .o_hit(o_hit)
   );

   typedef struct {
      int            fr;
      int            x;
      int            y;
      bit            pass;
      logic [23:0]   rgb;
      logic [NB-1:0] hit;
   } probe_t;

   probe_t        probes [96];
   int            np = 0;
   int            checks = 0, failures = 0;
   int            sync_err = 0;
   int            mid_line = -1, mid_hl = 0, mid_hr = 0;

   logic [23:0]   cap_rgb [VACT][HACT];
   logic [NB-1:0] cap_hit [VACT][HACT];
   bit            cap_v   [VACT][HACT];

   logic          p_de, p_hs, p_vs;
   logic [23:0]   p_rgb;
   int            p_x, p_y;

   function automatic logic [23:0] pix(input int x, input int y);
      return {8'(x + 1), 8'(y + 3), 8'h5A};
   endfunction

   task automatic add_p(input int fr, input int x, input int y, input bit pass,
                        input logic [23:0] rgb, input logic [NB-1:0] hit);
      probes[np] = '{fr, x, y, pass, rgb, hit};
      np++;
   endtask

   task automatic pp(input int fr, input int x, input int y);
      add_p(fr, x, y, 1'b1, 24'h0, '0);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   task automatic set_box(input int k, input int hl, input int hr, input int vl, input int vr,
                          input logic [23:0] col, input logic [23:0] lab,
                          input logic en, input logic bl);
      box_hl[k*CW +: CW]    = CW'(hl);
      box_hr[k*CW +: CW]    = CW'(hr);
      box_vl[k*CW +: CW]    = CW'(vl);
      box_vr[k*CW +: CW]    = CW'(vr);
      box_color[k*24 +: 24] = col;
      label_rgb[k*24 +: 24] = lab;
      box_en[k]             = en;
      box_blink[k]          = bl;
   endtask

   task automatic clear_pipe_model();
      p_de = 1'b0; p_hs = 1'b0; p_vs = 1'b0; p_rgb = '0; p_x = 0; p_y = 0;
   endtask

   task automatic clear_cap();
      for (int y = 0; y < VACT; y++)
         for (int x = 0; x < HACT; x++) cap_v[y][x] = 1'b0;
   endtask

   // One clock: drive inputs, then check outputs against the inputs of the previous call.
   task automatic cycle(input logic de, input logic hs, input logic vs, input int x, input int y);
      i_de = de; i_hsync = hs; i_vsync = vs;
      i_rgb = de ? pix(x, y) : BLANK_RGB;
      @(posedge clk); #1;
      if (o_de !== p_de || o_hsync !== p_hs || o_vsync !== p_vs ||
          (!p_de && (o_rgb !== p_rgb || o_hit !== '0)))
         sync_err++;
      if (p_de && p_x < HACT && p_y < VACT) begin
         cap_rgb[p_y][p_x] = o_rgb;
         cap_hit[p_y][p_x] = o_hit;
         cap_v[p_y][p_x]   = 1'b1;
      end
      p_de = de; p_hs = hs; p_vs = vs; p_rgb = i_rgb; p_x = x; p_y = y;
   endtask

   task automatic run_line(input int y);
      for (int x = 0; x < HACT; x++) cycle(1'b1, 1'b0, 1'b0, x, y);
      for (int b = 0; b < HBL; b++) cycle(1'b0, (b >= 1 && b < 3), 1'b0, 0, y);
   endtask

   task automatic run_frame();
      clear_cap();
      for (int i = 0; i < 2 * (HACT + HBL); i++) cycle(1'b0, 1'b0, 1'b1, 0, 0);
      for (int i = 0; i < 2 * HBL; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0);
      for (int y = 0; y < VACT; y++) begin
         if (y == mid_line) begin
            box_hl[0 +: CW] = CW'(mid_hl);
            box_hr[0 +: CW] = CW'(mid_hr);
         end
         run_line(y);
      end
      chk("sync_align", 32'(sync_err), 32'd0);
      sync_err = 0;
   endtask

   task automatic check_frame(input int fr);
      logic [23:0] er;
      for (int i = 0; i < np; i++) begin
         if (probes[i].fr == fr) begin
            er = probes[i].pass ? pix(probes[i].x, probes[i].y) : probes[i].rgb;
            checks++;
            if (!cap_v[probes[i].y][probes[i].x] ||
                cap_rgb[probes[i].y][probes[i].x] !== er ||
                cap_hit[probes[i].y][probes[i].x] !== probes[i].hit) begin
               failures++;
               $display("FAIL probe%0d fr%0d (%0d,%0d): got rgb=%06h hit=%b seen=%0d, want rgb=%06h hit=%b",
                        i, fr, probes[i].x, probes[i].y,
                        cap_rgb[probes[i].y][probes[i].x], cap_hit[probes[i].y][probes[i].x],
                        cap_v[probes[i].y][probes[i].x], er, probes[i].hit);
            end
         end
      end
   endtask

   initial begin
      // fr0: single green box with red label row
      add_p(0, 10, 5, 0, GRN, 4'b0001);  add_p(0, 11, 10, 0, GRN, 4'b0001);
      pp(0, 12, 10);                     add_p(0, 19, 10, 0, GRN, 4'b0001);
      add_p(0, 20, 15, 0, GRN, 4'b0001); pp(0, 21, 10);
      pp(0, 15, 10);                     add_p(0, 15, 5, 0, GRN, 4'b0001);
      add_p(0, 15, 6, 0, GRN, 4'b0001);  pp(0, 15, 7);
      add_p(0, 15, 14, 0, GRN, 4'b0001); pp(0, 15, 16);
      pp(0, 9, 5);
      add_p(0, 11, 3, 0, RED, 4'b0001);  add_p(0, 19, 3, 0, RED, 4'b0001);
      pp(0, 10, 3); pp(0, 20, 3); pp(0, 15, 4); pp(0, 15, 2);
      // fr1: four overlapping boxes, priorities and clamped thickness
      add_p(1, 20, 10, 0, BLU, 4'b0001); add_p(1, 30, 10, 0, RED, 4'b0010);
      add_p(1, 15, 5, 0, BLU, 4'b0011);  add_p(1, 16, 10, 0, RED, 4'b0010);
      add_p(1, 17, 3, 0, RED, 4'b0011);  add_p(1, 15, 3, 0, RED, 4'b0001);
      add_p(1, 25, 3, 0, YEL, 4'b0110);  add_p(1, 22, 3, 0, CYA, 4'b0010);
      add_p(1, 41, 4, 0, MAG, 4'b1000);  add_p(1, 30, 8, 0, RED, 4'b0110);
      pp(1, 41, 0); pp(1, 12, 10); pp(1, 36, 4);
      // fr2/fr3: mid-frame geometry change only lands on the next frame
      add_p(2, 10, 10, 0, GRN, 4'b0001); pp(2, 40, 10); add_p(2, 10, 12, 0, GRN, 4'b0001);
      add_p(3, 40, 10, 0, GRN, 4'b0001); add_p(3, 41, 10, 0, GRN, 4'b0001);
      pp(3, 10, 10);                     add_p(3, 46, 10, 0, GRN, 4'b0001);
      pp(3, 43, 10);                     add_p(3, 43, 5, 0, GRN, 4'b0001);
      // fr4: degenerate boxes never hit
      pp(4, 20, 5); pp(4, 20, 10); pp(4, 25, 12); pp(4, 25, 10); pp(4, 30, 15);
      // fr9: lines after reset with no FS yet
      pp(9, 10, 5); pp(9, 25, 5); pp(9, 20, 7);
      // fr10..15: blink half-period of two frames
      for (int f = 0; f < 6; f++) begin
         if (f == 2 || f == 3) pp(10 + f, 10, 10);
         else add_p(10 + f, 10, 10, 0, GRN, 4'b0001);
         add_p(10 + f, 25, 10, 0, RED, 4'b0010);
      end

      box_en = '0; box_blink = '0; box_hl = '0; box_hr = '0; box_vl = '0; box_vr = '0;
      box_color = '0; label_rgb = '0;

      reset_n = 1'b0; i_de = 1'b1; i_hsync = 1'b1; i_vsync = 1'b1; i_rgb = 24'hABCDEF;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_rgb", 32'(o_rgb), 32'd0);
      chk("rst_hsync", 32'(o_hsync), 32'd0);
      chk("rst_vsync", 32'(o_vsync), 32'd0);
      chk("rst_de", 32'(o_de), 32'd0);
      chk("rst_hit", 32'(o_hit), 32'd0);
      reset_n = 1'b1;
      clear_pipe_model();
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 0, 0);

      set_box(0, 10, 20, 5, 15, GRN, RED, 1'b1, 1'b0);
      run_frame();
      check_frame(0);

      set_box(0, 10, 20, 5, 15, BLU, RED, 1'b1, 1'b0);
      set_box(1, 15, 30, 5, 15, RED, CYA, 1'b1, 1'b0);
      set_box(2, 25, 35, 0, 8, YEL, 24'h111111, 1'b1, 1'b0);
      set_box(3, 40, 42, 1, 6, MAG, 24'h222222, 1'b1, 1'b0);
      run_frame();
      check_frame(1);

      set_box(0, 10, 20, 5, 15, GRN, RED, 1'b1, 1'b0);
      box_en[3:1] = 3'b000;
      mid_line = 8; mid_hl = 40; mid_hr = 46;
      run_frame();
      mid_line = -1;
      check_frame(2);
      run_frame();
      check_frame(3);

      set_box(0, 20, 20, 5, 15, GRN, RED, 1'b1, 1'b0);
      set_box(1, 25, 30, 15, 10, RED, CYA, 1'b1, 1'b0);
      run_frame();
      check_frame(4);

      // Reset in the middle of an active line, then lines with no FS.
      set_box(0, 10, 20, 5, 15, GRN, RED, 1'b1, 1'b1);
      set_box(1, 25, 35, 5, 15, RED, CYA, 1'b1, 1'b0);
      for (int x = 0; x < 8; x++) cycle(1'b1, 1'b0, 1'b0, x, 0);
      reset_n = 1'b0; i_de = 1'b1; i_hsync = 1'b1; i_vsync = 1'b0; i_rgb = pix(8, 0);
      @(posedge clk); #1;
      chk("rst_mid_rgb", 32'(o_rgb), 32'd0);
      chk("rst_mid_de", 32'(o_de), 32'd0);
      chk("rst_mid_hsync", 32'(o_hsync), 32'd0);
      chk("rst_mid_hit", 32'(o_hit), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      clear_pipe_model();
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 0, 0);
      clear_cap();
      for (int y = 0; y < 8; y++) run_line(y);
      chk("sync_align_nofs", 32'(sync_err), 32'd0);
      sync_err = 0;
      check_frame(9);

      for (int f = 0; f < 6; f++) begin
         run_frame();
         check_frame(10 + f);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
